// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Target side of the memory-stage load/store interface. Accepts one request at
// a time (byte/half/word loads and stores, plus 4-word burst reads for 128-bit
// matrix rows) and answers with registered response beats. Read data is
// returned shifted down to bit 0 with zero-filled upper bits. Sign extension
// is left to the requester.
//
// Parameters
//   DROM_SPACE  memory depth in 32-bit words (power of two). Word addresses
//               wrap modulo this depth.
//   RD_LATENCY  cycles from load acceptance to the first response beat (1..4).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request this cycle (IDLE only)
//   req_write  1 = store, 0 = load
//   req_burst  1 = 4-word burst read
//   req_size   00 byte, 01 half, 10 word, 11 illegal
//   req_addr   byte address
//   req_wdata  store data, right-aligned
//   rsp_valid  response beat valid, one cycle per beat
//   rsp_rdata  read data aligned to bit 0, zero otherwise
//   rsp_last   final beat of a response
//   rsp_err    request rejected, no memory side effect
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DROM_SPACE = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_burst,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_last,
    output logic        rsp_err
);

    localparam int AW = $clog2(DROM_SPACE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BEAT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [31:0] mem [DROM_SPACE];

    // Counters: dead cycles left before the first beat, and index of the
    // beat currently on the response outputs.
    logic [1:0] wait_cnt, wait_cnt_nxt;
    logic [1:0] beat_cnt, beat_cnt_nxt;

    // Request fields captured at acceptance for use in WAIT/BEAT.
    logic [AW-1:0] base_idx;
    logic [1:0]    lo_q;
    logic [1:0]    size_q;
    logic          burst_q;

    logic          accept;
    logic          req_err;
    logic [AW-1:0] req_idx;

    logic          wr_en;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    logic [AW-1:0] rd_idx;
    logic [1:0]    rd_size;
    logic [1:0]    rd_lo;
    logic          rd_burst;
    logic [31:0]   rd_word;

    logic          emit_valid;
    logic          emit_last;
    logic          emit_err;
    logic [31:0]   emit_rdata;

    // Upper address bits are dropped on purpose: the array wraps silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[AW+1:2];

    assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (req_burst && req_addr[3:0] != 4'h0)
                  || (req_burst && req_write);

    // -------------------------------------------------------------------------
    // Store path: lane enables and lane-replicated data. Gated by rst so a
    // request held through reset cannot slip a write in.
    // -------------------------------------------------------------------------
    assign wr_en = accept && req_write && !req_err && !rst;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        case (req_size)
            2'b00: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
            default: ;
        endcase
    end

    // NOTE: the memory array has no reset; contents and committed stores
    // survive rst, and a reset branch would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read select: in IDLE the live request addresses the array (used when the
    // first beat is due on the acceptance edge); later the captured fields do.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_idx   = base_idx;
        rd_size  = size_q;
        rd_lo    = lo_q;
        rd_burst = burst_q;
        case (state)
            IDLE: begin
                rd_idx   = req_idx;
                rd_size  = req_size;
                rd_lo    = req_addr[1:0];
                rd_burst = req_burst;
            end
            BEAT: begin
                // Next burst word; index arithmetic wraps modulo DROM_SPACE.
                rd_idx = base_idx + AW'(beat_cnt) + AW'(1);
            end
            default: ;
        endcase
    end

    assign rd_word = mem[rd_idx];

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lo,
                                                 input logic        burst);
        logic [31:0] shifted;
        shifted = word >> {lo, 3'b000};
        if (burst || size == 2'b10) begin
            lane_extract = word;
        end else if (size == 2'b01) begin
            lane_extract = {16'h0000, shifted[15:0]};
        end else begin
            lane_extract = {24'h000000, shifted[7:0]};
        end
    endfunction

    // -------------------------------------------------------------------------
    // FSM next state. The emit_* signals are the values the response
    // registers take on the coming edge, so a beat is prepared one cycle
    // before it is visible. WAIT covers the RD_LATENCY-1 dead cycles; with
    // RD_LATENCY=1 there are none and the first beat launches from IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        beat_cnt_nxt = beat_cnt;
        emit_valid   = 1'b0;
        emit_last    = 1'b0;
        emit_err     = 1'b0;
        emit_rdata   = 32'h0;

        case (state)
            IDLE: begin
                if (accept) begin
                    beat_cnt_nxt = 2'd0;
                    if (req_err) begin
                        emit_valid = 1'b1;
                        emit_last  = 1'b1;
                        emit_err   = 1'b1;
                        state_nxt  = RESP;
                    end else if (req_write) begin
                        emit_valid = 1'b1;
                        emit_last  = 1'b1;
                        state_nxt  = RESP;
                    end else if (RD_LATENCY == 1) begin
                        emit_valid = 1'b1;
                        emit_last  = !req_burst;
                        emit_rdata = lane_extract(rd_word, rd_size, rd_lo, rd_burst);
                        state_nxt  = BEAT;
                    end else begin
                        wait_cnt_nxt = 2'(RD_LATENCY - 2);
                        state_nxt    = WAIT;
                    end
                end
            end

            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    emit_valid = 1'b1;
                    emit_last  = !burst_q;
                    emit_rdata = lane_extract(rd_word, rd_size, rd_lo, rd_burst);
                    state_nxt  = BEAT;
                end else begin
                    wait_cnt_nxt = wait_cnt - 2'd1;
                end
            end

            BEAT: begin
                // beat_cnt names the beat currently on the outputs.
                if (burst_q && beat_cnt != 2'd3) begin
                    beat_cnt_nxt = beat_cnt + 2'd1;
                    emit_valid   = 1'b1;
                    emit_last    = (beat_cnt == 2'd2);
                    emit_rdata   = rd_word;
                end else begin
                    state_nxt = IDLE;
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters, captured request and registered response outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 2'd0;
            beat_cnt  <= 2'd0;
            base_idx  <= '0;
            lo_q      <= 2'd0;
            size_q    <= 2'd0;
            burst_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // pre-edge values regardless of statement order.
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            beat_cnt  <= beat_cnt_nxt;
            rsp_valid <= emit_valid;
            rsp_last  <= emit_last;
            rsp_err   <= emit_err;
            rsp_rdata <= emit_rdata;
            if (accept) begin
                base_idx <= req_idx;
                lo_q     <= req_addr[1:0];
                size_q   <= req_size;
                burst_q  <= req_burst;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders (RD_LATENCY 1 and 3) receive identical requests. A word
// array in the bench models memory; each transaction derives its expected
// beats from that array and checks both responders cycle by cycle.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic        req_burst;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        ready1, valid1, last1, err1;
    logic [31:0] rdata1;
    logic        ready3, valid3, last3, err3;
    logic [31:0] rdata3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DROM_SPACE(DEPTH), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(ready1),
        .req_write(req_write), .req_burst(req_burst),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid1), .rsp_rdata(rdata1),
        .rsp_last(last1), .rsp_err(err1)
    );

    dmem_responder #(.DROM_SPACE(DEPTH), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(ready3),
        .req_write(req_write), .req_burst(req_burst),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid3), .rsp_rdata(rdata3),
        .rsp_last(last3), .rsp_err(err3)
    );

    // ---------------------------------------------------------------- model
    function automatic bit model_err(bit wr, bit bu, logic [1:0] sz, logic [31:0] a);
        if (sz == 3) return 1;
        if (sz == 1 && (a % 2) != 0) return 1;
        if (sz == 2 && (a % 4) != 0) return 1;
        if (bu && (a % 16) != 0) return 1;
        if (bu && wr) return 1;
        return 0;
    endfunction

    function automatic int word_of(logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic model_store(logic [1:0] sz, logic [31:0] a, logic [31:0] d);
        int i;
        int sh;
        logic [31:0] w;
        i = word_of(a);
        w = model_mem[i];
        if (sz == 0) begin
            sh = 8 * int'(a % 4);
            w = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end else if (sz == 1) begin
            sh = 16 * int'((a / 2) % 2);
            w = (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end else begin
            w = d;
        end
        model_mem[i] = w;
    endtask

    function automatic logic [31:0] model_load(logic [1:0] sz, logic [31:0] a);
        logic [31:0] w;
        w = model_mem[word_of(a)];
        if (sz == 0) return (w >> (8 * int'(a % 4))) & 32'hFF;
        if (sz == 1) return (w >> (16 * int'((a / 2) % 2))) & 32'hFFFF;
        return w;
    endfunction

    // ---------------------------------------------------------- transaction
    // Drives one request when both responders are ready, then compares
    // {req_ready, rsp_valid, rsp_last, rsp_err, rsp_rdata} of both every cycle
    // until the slower one is idle again (plus 'gap' idle cycles).
    task automatic do_txn(input string name, input bit wr, input bit bu,
                          input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int gap,
                          output logic [31:0] first1, output logic [31:0] first3);
        bit          e;
        int          nb;
        int          lat [2];
        int          busy [2];
        int          win;
        int          guard;
        int          k;
        bit          in_beat;
        logic [31:0] ed [4];
        logic [35:0] got;
        logic [35:0] exp;

        lat[0] = 1;
        lat[1] = 3;
        first1 = 32'h0;
        first3 = 32'h0;
        for (int j = 0; j < 4; j++) ed[j] = 32'h0;

        guard = 0;
        while (!(ready1 && ready3) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!(ready1 && ready3)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s ready_timeout got ready1=%0b ready3=%0b need 1/1", name, ready1, ready3);
            return;
        end

        e  = model_err(wr, bu, sz, a);
        nb = 0;
        if (!e && wr) model_store(sz, a, d);
        if (!e && !wr) begin
            nb = bu ? 4 : 1;
            for (int j = 0; j < nb; j++)
                ed[j] = bu ? model_mem[(word_of(a) + j) % DEPTH] : model_load(sz, a);
        end
        for (int i = 0; i < 2; i++) busy[i] = (nb == 0) ? 1 : lat[i] + nb - 1;
        win = busy[1] + 1 + gap;

        req_valid = 1'b1;
        req_write = wr;
        req_burst = bu;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;

        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                got = (i == 0) ? {ready1, valid1, last1, err1, rdata1}
                               : {ready3, valid3, last3, err3, rdata3};
                if (nb == 0) begin
                    in_beat = (c == 1);
                    exp = {c > busy[i], in_beat, in_beat, in_beat && e, 32'h0};
                end else begin
                    in_beat = (c >= lat[i]) && (c < lat[i] + nb);
                    k = in_beat ? c - lat[i] : 0;
                    exp = {c > busy[i], in_beat, in_beat && (k == nb - 1), 1'b0,
                           in_beat ? ed[k] : 32'h0};
                end
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL %s lat=%0d cycle=%0d got {rdy,vld,last,err,data}=%h need %h",
                             name, lat[i], c, got, exp);
                end
                if (c == ((nb == 0) ? 1 : lat[i])) begin
                    if (i == 0) first1 = got[31:0];
                    else        first3 = got[31:0];
                end
            end
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [35:0] got;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_burst = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'hA5A5_A5A5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            got = {ready1, valid1, last1, err1, rdata1};
            n_cmp++;
            if (got !== {4'b1000, 32'h0}) begin
                n_bad++;
                $display("FAIL reset_hold lat=1 got=%h need=%h", got, {4'b1000, 32'h0});
            end
            got = {ready3, valid3, last3, err3, rdata3};
            n_cmp++;
            if (got !== {4'b1000, 32'h0}) begin
                n_bad++;
                $display("FAIL reset_hold lat=3 got=%h need=%h", got, {4'b1000, 32'h0});
            end
        end
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_preload();
        logic [31:0] f1, f3;
        for (int i = 0; i < 64; i++)
            do_txn("preload", 1, 0, 2'b10, 32'(i * 4), $urandom, 0, f1, f3);
        for (int i = 1008; i < DEPTH; i++)
            do_txn("preload", 1, 0, 2'b10, 32'(i * 4), $urandom, 0, f1, f3);
    endtask

    task automatic test_store_load();
        logic [31:0] f1, f3;
        do_txn("st_word", 1, 0, 2'b10, 32'h10, 32'hDEAD_BEEF, 0, f1, f3);
        do_txn("st_byte", 1, 0, 2'b00, 32'h12, 32'h0000_005A, 0, f1, f3);
        do_txn("ld_word", 0, 0, 2'b10, 32'h10, 32'h0, 1, f1, f3);
        n_cmp++;
        if (f1 !== 32'hDE5A_BEEF) begin
            n_bad++;
            $display("FAIL ld_word_value got=%h need=%h", f1, 32'hDE5A_BEEF);
        end
    endtask

    task automatic test_sublane();
        logic [31:0] f1, f3;
        do_txn("ld_byte", 0, 0, 2'b00, 32'h13, 32'h0, 0, f1, f3);
        n_cmp++;
        if (f3 !== 32'h0000_00DE) begin
            n_bad++;
            $display("FAIL ld_byte_value got=%h need=%h", f3, 32'h0000_00DE);
        end
        do_txn("ld_half", 0, 0, 2'b01, 32'h12, 32'h0, 0, f1, f3);
        n_cmp++;
        if (f1 !== 32'h0000_DE5A) begin
            n_bad++;
            $display("FAIL ld_half_value got=%h need=%h", f1, 32'h0000_DE5A);
        end
    endtask

    task automatic test_burst();
        logic [31:0] f1, f3;
        for (int i = 0; i < 4; i++)
            do_txn("burst_fill", 1, 0, 2'b10, 32'(32'h20 + 4 * i), 32'(i + 1), 0, f1, f3);
        do_txn("burst_20", 0, 1, 2'b10, 32'h20, 32'h0, 1, f1, f3);
        n_cmp++;
        if (f3 !== 32'h1) begin
            n_bad++;
            $display("FAIL burst_first_beat got=%h need=%h", f3, 32'h1);
        end
    endtask

    task automatic test_errors();
        logic [31:0] f1, f3;
        do_txn("err_half", 1, 0, 2'b01, 32'h1, 32'hFFFF_FFFF, 0, f1, f3);
        do_txn("err_word", 1, 0, 2'b10, 32'h2, 32'hFFFF_FFFF, 0, f1, f3);
        do_txn("err_word_ld", 0, 0, 2'b10, 32'h12, 32'h0, 0, f1, f3);
        do_txn("err_burst_mis", 0, 1, 2'b10, 32'h24, 32'h0, 0, f1, f3);
        do_txn("err_burst_wr", 1, 1, 2'b10, 32'h20, 32'hFFFF_FFFF, 0, f1, f3);
        do_txn("err_size3", 1, 0, 2'b11, 32'h10, 32'hFFFF_FFFF, 0, f1, f3);
        do_txn("reread_0", 0, 0, 2'b10, 32'h0, 32'h0, 0, f1, f3);
        do_txn("reread_10", 0, 0, 2'b10, 32'h10, 32'h0, 0, f1, f3);
        do_txn("reread_20", 0, 1, 2'b10, 32'h20, 32'h0, 0, f1, f3);
    endtask

    task automatic test_wrap();
        logic [31:0] f1, f3;
        do_txn("wrap_st", 1, 0, 2'b10, 32'h1000, 32'h1234_5678, 0, f1, f3);
        do_txn("wrap_ld", 0, 0, 2'b10, 32'h0, 32'h0, 0, f1, f3);
        n_cmp++;
        if (f1 !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL wrap_value got=%h need=%h", f1, 32'h1234_5678);
        end
        do_txn("wrap_burst", 0, 1, 2'b10, 32'hFF0, 32'h0, 0, f1, f3);
        do_txn("alias_burst", 0, 1, 2'b10, 32'h1FF0, 32'h0, 0, f1, f3);
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] f1, f3;
        logic [35:0] got;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_burst = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        got = {ready1, valid1, ready3, valid3, 32'h0};
        n_cmp++;
        if (got !== {4'b1010, 32'h0}) begin
            n_bad++;
            $display("FAIL rst_in_wait_async got=%h need=%h", got, {4'b1010, 32'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            got = {ready1, valid1, ready3, valid3, rdata3};
            n_cmp++;
            if (got !== {4'b1010, 32'h0}) begin
                n_bad++;
                $display("FAIL rst_in_wait_after cycle=%0d got=%h need=%h", c, got, {4'b1010, 32'h0});
            end
        end
        do_txn("persist_10", 0, 0, 2'b10, 32'h10, 32'h0, 0, f1, f3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] f1, f3;
        do_txn("b2b_st", 1, 0, 2'b01, 32'h32, 32'h0000_C0DE, 0, f1, f3);
        do_txn("b2b_ld", 0, 0, 2'b10, 32'h30, 32'h0, 0, f1, f3);
        do_txn("b2b_burst", 0, 1, 2'b10, 32'h30, 32'h0, 0, f1, f3);
        do_txn("b2b_err", 0, 0, 2'b11, 32'h30, 32'h0, 0, f1, f3);
        do_txn("b2b_byte", 0, 0, 2'b00, 32'h33, 32'h0, 0, f1, f3);
    endtask

    task automatic test_random();
        logic [31:0] f1, f3;
        logic [31:0] a;
        logic [1:0]  sz;
        bit          bu;
        bit          wr;
        int          idx;
        for (int n = 0; n < 120; n++) begin
            bu  = ($urandom_range(0, 9) < 2);
            wr  = bu ? ($urandom_range(0, 7) == 0) : bit'($urandom_range(0, 1));
            idx = $urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom_range(1008, 1023);
            if (bu) begin
                idx = idx & ~3;
                sz  = 2'b10;
                a   = 32'(idx * 4 + (($urandom_range(0, 5) == 0) ? 4 : 0));
            end else begin
                sz = 2'($urandom_range(0, 3));
                a  = 32'(idx * 4 + $urandom_range(0, 3));
            end
            a = a + 32'(DEPTH * 4 * $urandom_range(0, 3));
            do_txn("random", wr, bu, sz, a, $urandom, $urandom_range(0, 2), f1, f3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running need=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_burst = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        test_reset();
        test_preload();
        test_store_load();
        test_sublane();
        test_burst();
        test_errors();
        test_wrap();
        test_reset_in_wait();
        test_back_to_back();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
